// File: rtl/cmd_sequencer.sv
// cmd_sequencer: buffers host commands in a FIFO and issues them one at a time
// to RemoteComm, checking each response for the ack byte, retrying failed
// attempts and halting with a sticky error once the retries are used up.
`timescale 1ns/1ps
module cmd_sequencer #(
  parameter int         DEPTH     = 8,
  parameter int         TIMEOUT   = 200000,
  parameter int         MAX_RETRY = 2,
  parameter logic [7:0] ACK       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_in,
  input  logic        push,
  output logic        full,
  output logic        empty,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  input  logic        clr_err,
  output logic        busy,
  output logic        cmd_done,
  output logic        err,
  output logic [15:0] err_cmd
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic [15:0]   r_cmd;
  logic [15:0]   r_err_cmd;
  logic          r_snd_cmd;
  logic          r_cmd_done;
  logic          r_err;
  logic          r_busy;
  logic          r_full;
  logic          r_empty;

  logic          w_pop;
  logic          w_push_ok;
  logic          w_timeout;
  logic          w_ack;
  logic          w_fail;
  logic          w_retry_ok;
  logic          w_give_up;
  logic          w_snd_next;
  logic          w_done_next;
  logic          w_err_next;
  logic          w_busy_next;
  logic          w_full_next;
  logic          w_empty_next;

  // The head is taken only from IDLE; a final failure flushes the FIFO and
  // wins over any push arriving in the same cycle.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_timeout  = (r_timer == TIMER_LAST);
  assign w_ack      = resp_rdy && (resp == ACK);
  assign w_retry_ok = (r_retry < RETRY_LAST);
  assign w_give_up  = w_fail && !w_retry_ok;
  assign w_push_ok  = push && (r_state != S_HALT) && !w_give_up &&
                      ((r_count != FULL_COUNT) || w_pop);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; handshake inputs are tested before the timeout so they win
  always_comb begin
    w_state_next = r_state;
    w_fail       = 1'b0;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_next = S_SEND;
      S_SEND:      w_state_next = S_WAIT_SNT;
      S_WAIT_SNT: begin
        if (cmd_snt)        w_state_next = S_WAIT_RESP;
        else if (w_timeout) w_fail = 1'b1;
      end
      S_WAIT_RESP: begin
        if (resp_rdy) begin
          if (w_ack) w_state_next = S_IDLE;
          else       w_fail = 1'b1;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end
      S_HALT:      if (clr_err) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
    if (w_fail) w_state_next = w_retry_ok ? S_SEND : S_HALT;
  end

  // Output logic: next values of the registered Moore outputs
  always_comb begin
    w_snd_next   = (w_state_next == S_SEND);
    w_done_next  = (r_state == S_WAIT_RESP) && w_ack;
    w_err_next   = r_err;
    if (w_give_up)                             w_err_next = 1'b1;
    else if ((r_state == S_HALT) && clr_err)   w_err_next = 1'b0;
    w_busy_next  = (w_state_next != S_IDLE) || (w_count_next != '0);
    w_full_next  = (w_count_next == FULL_COUNT);
    w_empty_next = (w_count_next == '0);
  end

  // FIFO occupancy after this cycle's push, pop or flush
  always_comb begin
    w_count_next = r_count;
    if (w_give_up)                 w_count_next = '0;
    else if (w_push_ok && !w_pop)  w_count_next = r_count + CW'(1);
    else if (!w_push_ok && w_pop)  w_count_next = r_count - CW'(1);
  end

  // FIFO storage; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= cmd_in;
  end

  // FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst || w_give_up) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
    end
    if (rst) r_count <= '0;
    else     r_count <= w_count_next;
  end

  // Command register (registered RAM read), wait timer and retry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd   <= '0;
      r_timer <= '0;
      r_retry <= '0;
    end else begin
      if (w_pop) r_cmd <= r_mem[r_rd_ptr];
      if (((r_state == S_WAIT_SNT) && !cmd_snt) || (r_state == S_WAIT_RESP))
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
      if (w_pop)                       r_retry <= '0;
      else if (w_fail && w_retry_ok)   r_retry <= r_retry + RW'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snd_cmd  <= 1'b0;
      r_cmd_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_cmd  <= '0;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_snd_cmd  <= w_snd_next;
      r_cmd_done <= w_done_next;
      r_err      <= w_err_next;
      if (w_give_up) r_err_cmd <= r_cmd;
      r_busy     <= w_busy_next;
      r_full     <= w_full_next;
      r_empty    <= w_empty_next;
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign cmd      = r_cmd;
  assign snd_cmd  = r_snd_cmd;
  assign busy     = r_busy;
  assign cmd_done = r_cmd_done;
  assign err      = r_err;
  assign err_cmd  = r_err_cmd;

endmodule
